// File: rtl/lc3_mem_io_ctrl.sv
// Purpose: LC-3 memory + memory-mapped I/O controller (RAM, KBSR/KBDR/DSR/DDR).
// Latency: R pulses MEM_LATENCY cycles after MIO_EN is first seen in IDLE.
// Backpressure: MIO_EN is held by the requester until R. The keyboard stalls via kbd_ready. The display holds disp_valid until disp_ready.
//
// Ports:
//   clk, rstn              clock (rising edge), asynchronous active-low reset
//   MIO_EN, R_W, MAR, MDR  access request, 1=write, address, write data
//   R, MEMout              one-cycle completion pulse, read data (held until next read)
//   kbd_valid/kbd_data/kbd_ready     keyboard character source handshake
//   disp_valid/disp_data/disp_ready  display character sink handshake
//   irq                    device interrupt request
//
// Optional feature: define LC3_IO_IRQ_EN to get writable interrupt-enable bits
// KBSR[14]/DSR[14] and a registered irq. Without it, both bits read 0 and irq is 0.
// MEM_LATENCY must lie in 1..15 (4-bit down counter).

module lc3_mem_io_ctrl #(
    parameter int MEM_LATENCY = 3,
    parameter int MEM_AW      = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        MIO_EN,
    input  logic        R_W,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    output logic        R,
    output logic [15:0] MEMout,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_data,
    output logic        kbd_ready,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ready,
    output logic        irq
);

    localparam logic [15:0] A_KBSR = 16'hFE00;
    localparam logic [15:0] A_KBDR = 16'hFE02;
    localparam logic [15:0] A_DSR  = 16'hFE04;
    localparam logic [15:0] A_DDR  = 16'hFE06;
    localparam int          RAM_WORDS = 1 << MEM_AW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;
    logic [3:0]  w_next_cnt;
    logic        w_capture;

    // Captured request
    logic [15:0] r_addr;
    logic [15:0] r_wdat;
    logic        r_rw;

    // Device registers
    logic        r_kbsr_rdy;
    logic [7:0]  r_kbdr;
    logic        r_dsr_rdy;
    logic [7:0]  r_ddr;
    logic        r_disp_vld;
    logic        w_kbsr_ie;
    logic        w_dsr_ie;

    logic [15:0] r_memout;
    logic [15:0] r_mem [0:RAM_WORDS-1];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (MIO_EN) begin
                    w_capture = 1'b1;
                    if (MEM_LATENCY == 1) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_BUSY;
                        w_next_cnt   = 4'(MEM_LATENCY - 1);
                    end
                end
            end
            S_BUSY: begin
                // Leave on the cycle the counter would hit zero
                if (r_cnt <= 4'd1) begin
                    w_next_state = S_DONE;
                    w_next_cnt   = 4'd0;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_addr <= 16'h0;
            r_wdat <= 16'h0;
            r_rw   <= 1'b0;
        end else if (w_capture) begin
            r_addr <= MAR;
            r_wdat <= MDR;
            r_rw   <= R_W;
        end
    end

    // ------------------------------------------------------------------
    // Read path: MEMout loads on entry to DONE. With MEM_LATENCY=1 entry
    // happens from IDLE, where the capture registers are not yet loaded,
    // so the live request is used in that case.
    // ------------------------------------------------------------------
    logic [15:0]       w_acc_addr;
    logic              w_acc_rw;
    logic              w_acc_io;
    logic              w_acc_in_ram;
    logic [MEM_AW-1:0] w_acc_idx;
    logic [15:0]       w_rd_dat;
    logic              w_enter_done;

    assign w_acc_addr   = (r_state == S_IDLE) ? MAR : r_addr;
    assign w_acc_rw     = (r_state == S_IDLE) ? R_W : r_rw;
    assign w_acc_io     = (w_acc_addr[15:9] == 7'h7F);
    assign w_acc_in_ram = ~w_acc_io && ((32'(w_acc_addr) >> MEM_AW) == 32'd0);
    assign w_acc_idx    = w_acc_addr[MEM_AW-1:0];
    assign w_enter_done = (w_next_state == S_DONE);

    always_comb begin
        w_rd_dat = 16'h0;
        if (w_acc_io) begin
            case (w_acc_addr)
                A_KBSR:  w_rd_dat = {r_kbsr_rdy, w_kbsr_ie, 14'b0};
                A_KBDR:  w_rd_dat = {8'b0, r_kbdr};
                A_DSR:   w_rd_dat = {r_dsr_rdy, w_dsr_ie, 14'b0};
                A_DDR:   w_rd_dat = {8'b0, r_ddr};
                default: w_rd_dat = 16'h0;
            endcase
        end else if (w_acc_in_ram) begin
            w_rd_dat = r_mem[w_acc_idx];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_memout <= 16'h0;
        end else if (w_enter_done && !w_acc_rw) begin
            r_memout <= w_rd_dat;
        end
    end

    // ------------------------------------------------------------------
    // DONE-cycle actions (all use the captured request)
    // ------------------------------------------------------------------
    logic w_done;
    logic w_wr;
    logic w_wr_io;
    logic w_wr_in_ram;
    logic w_kbdr_rd;
    logic w_ddr_wr;

    assign w_done      = (r_state == S_DONE);
    assign w_wr        = w_done & r_rw;
    assign w_wr_io     = (r_addr[15:9] == 7'h7F);
    assign w_wr_in_ram = ~w_wr_io && ((32'(r_addr) >> MEM_AW) == 32'd0);
    assign w_kbdr_rd   = w_done & ~r_rw & (r_addr == A_KBDR);
    assign w_ddr_wr    = w_wr & (r_addr == A_DDR) & r_dsr_rdy;

    // RAM contents survive reset; no reset branch here
    always_ff @(posedge clk) begin
        if (w_wr && w_wr_in_ram) begin
            r_mem[r_addr[MEM_AW-1:0]] <= r_wdat;
        end
    end

    // Keyboard: a KBDR read clears ready and takes priority over a
    // character arriving in the same cycle, which then waits a cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_kbsr_rdy <= 1'b0;
            r_kbdr     <= 8'h0;
        end else if (w_kbdr_rd) begin
            r_kbsr_rdy <= 1'b0;
        end else if (kbd_valid && !r_kbsr_rdy) begin
            r_kbdr     <= kbd_data;
            r_kbsr_rdy <= 1'b1;
        end
    end

    // Display: DSR ready and disp_valid are complementary, so a DDR write
    // can never coincide with a display handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dsr_rdy  <= 1'b1;
            r_ddr      <= 8'h0;
            r_disp_vld <= 1'b0;
        end else if (w_ddr_wr) begin
            r_ddr      <= r_wdat[7:0];
            r_disp_vld <= 1'b1;
            r_dsr_rdy  <= 1'b0;
        end else if (r_disp_vld && disp_ready) begin
            r_disp_vld <= 1'b0;
            r_dsr_rdy  <= 1'b1;
        end
    end

`ifdef LC3_IO_IRQ_EN
    logic r_kbsr_ie;
    logic r_dsr_ie;
    logic r_irq;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_kbsr_ie <= 1'b0;
            r_dsr_ie  <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            if (w_wr && (r_addr == A_KBSR)) r_kbsr_ie <= r_wdat[14];
            if (w_wr && (r_addr == A_DSR))  r_dsr_ie  <= r_wdat[14];
            // Registered, so irq trails the status bits by one cycle
            r_irq <= (r_kbsr_rdy & r_kbsr_ie) | (r_dsr_rdy & r_dsr_ie);
        end
    end

    assign w_kbsr_ie = r_kbsr_ie;
    assign w_dsr_ie  = r_dsr_ie;
    assign irq       = r_irq;
`else
    assign w_kbsr_ie = 1'b0;
    assign w_dsr_ie  = 1'b0;
    assign irq       = 1'b0;
`endif

    assign R          = w_done;
    assign MEMout     = r_memout;
    assign kbd_ready  = ~r_kbsr_rdy;
    assign disp_valid = r_disp_vld;
    assign disp_data  = r_ddr;

endmodule
